// File: rtl/pla_cmd_encoder.sv
// pla_cmd_encoder: serialises a decoded control-request vector into 8-bit
// code words, lowest request index first, over valid/ready handshakes.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready for a new request vector; no code word presented
//   S_EMIT | presenting code words from the pending mask, one per transfer
//
// Code word layout: [7]=last, [6:5]=2'b00, [4:0]=request index.
// Bit 0 of the request vector is reserved. It is never emitted, and it
// raises the sticky err_rsvd flag. A vector with no emittable bits still
// produces one marker word 8'h80, so every accepted vector yields a "last".
module pla_cmd_encoder #(
  parameter int VEC_W = 31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic [CNT_W-1:0] vec_count,
  output logic             err_rsvd
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic [VEC_W-1:0] ONE = VEC_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_pending;
  logic [7:0]       r_code;
  logic [7:0]       w_code_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic [VEC_W-1:0] w_captured;
  logic [VEC_W-1:0] w_remaining;

  // Lowest set index of the mask; last when at most one bit is set
  // (an empty mask encodes as the 8'h80 marker).
  function automatic logic [7:0] f_encode(input logic [VEC_W-1:0] p);
    logic [4:0] idx;
    idx = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (p[i]) idx = 5'(i);
    end
    f_encode = {((p & (p - ONE)) == '0), 2'b00, idx};
  endfunction

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_xfer      = (r_state == S_EMIT) && out_ready;
  assign w_last      = r_code[7];
  assign w_captured  = in_vec & ~ONE;
  assign w_remaining = r_pending & ~(ONE << r_code[4:0]);

  // Next state and next registered code word.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EMIT;
          w_code_nxt  = f_encode(w_captured);
        end
      end
      S_EMIT: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = 8'h00;
          end else begin
            w_code_nxt  = f_encode(w_remaining);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = 8'h00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pending mask, code word, vector counter and sticky reserved-bit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_code    <= 8'h00;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_code <= w_code_nxt;
      if (w_accept)    r_pending <= w_captured;
      else if (w_xfer) r_pending <= w_remaining;
      if (w_xfer && w_last)      r_count <= r_count + CNT_W'(1);
      if (w_accept && in_vec[0]) r_err   <= 1'b1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign out_code  = r_code;
  assign vec_count = r_count;
  assign err_rsvd  = r_err;

endmodule

// File: doc/pla_cmd_encoder.md
Name: pla_cmd_encoder

Overview:
- Sequential encoder that sits on the upstream side of the 8-in/31-out combinational control decoder.
- Accepts a 31-bit decoded control-request vector (bit i corresponds to decoder output v8.i) over a valid/ready handshake.
- Serialises each set request bit into an 8-bit code word, lowest index first, over a second valid/ready handshake.
- Bit 0 is the decoder's constant-zero output, so it is reserved and treated as an error.

Parameters:
- VEC_W, 31, request vector width; the index field is 5 bits, so VEC_W <= 32.
- CNT_W, 16, width of the processed-vector counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request vector valid.
- in_ready  output  1  encoder can accept a vector.
- in_vec  input  VEC_W  request vector; bit i = request i.
- out_valid  output  1  code word valid.
- out_ready  input  1  downstream accepts code word.
- out_code  output  8  [7]=last, [6:5]=2'b00, [4:0]=request index.
- vec_count  output  CNT_W  number of vectors fully emitted, wraps modulo 2^CNT_W.
- err_rsvd  output  1  sticky; set when an accepted vector had bit 0 set.

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, pending mask=0, out_valid=0, out_code=8'h00, in_ready=1, vec_count=0, err_rsvd=0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready, capture pending = in_vec & ~1 (bit 0 masked off), then go to EMIT.
  - If in_vec[0]=1, set err_rsvd; it stays set until reset.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_code[4:0] = index of the lowest set bit of pending.
  - out_code[7] = 1 when pending has exactly one bit set.
  - If pending==0 at entry (empty or bit-0-only vector), emit a single marker 8'h80 (last=1, index=0).
- Transfer occurs on out_valid&out_ready:
  - Clear the emitted bit from pending.
  - If last=1: vec_count increments and the state returns to IDLE in the next cycle.
  - Otherwise stay in EMIT and present the next index in the next cycle.
- Stall: while out_valid=1 and out_ready=0, out_code and out_valid are held stable (no change of any bit).
- Latency:
  - First code word is valid the cycle after input acceptance.
  - Throughput is one code per cycle while out_ready=1.
  - A vector with k set bits (k>=1, excluding bit 0) occupies k EMIT cycles plus one IDLE cycle before the next acceptance.
- out_code is registered (no combinational path from in_vec or out_ready to out_code/out_valid). in_ready is a function of state only.
- in_valid during EMIT is ignored; the upstream must hold the vector until in_ready.
- vec_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-EMIT immediately clears all state and the pending mask. Remaining codes are discarded; no partial last is emitted.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset, then in_vec=31'h0000_0006 with in_valid=1, out_ready=1 -> out_code 8'h01 next cycle, then 8'h82; vec_count=1; in_ready returns high one cycle after the 8'h82 transfer.
- in_vec=31'h4000_0000 -> single code 8'h9E (last, index 30); err_rsvd stays 0.
- in_vec=31'h0000_0001 -> single marker 8'h80; err_rsvd=1 and remains 1 across the next vector 31'h8 (emits 8'h83).
- in_vec=31'h0000_0102, out_ready low for 3 cycles after out_valid -> out_code held at 8'h01 for all stall cycles; then 8'h01, 8'h88 on release.
- Preload so vec_count=16'hFFFF, send 31'h2 -> emits 8'h81 and vec_count=16'h0000.
- Send 31'h7FFF_FFFE and assert rst after the 5th code -> out_valid=0, in_ready=1, pending cleared immediately; a following vector 31'h4 yields exactly 8'h82.
